// File: rtl/single_cycle_processor.sv
// single_cycle_processor: LEGv8 subset core, one instruction per clock.
// Fetch, decode, register read, ALU, data memory and write-back all settle
// within one period; register, memory and PC state update together on the
// rising edge. Reset is synchronous and active-low.
// Optional feature macro: SCP_BRANCH_EN enables CBZ and B. Without it both
// decode as NOP and the PC always advances by 4.

module scp_pc (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] next_pc,
  output logic [63:0] out
);
  // Program counter; reset returns execution to address 0
  always_ff @(posedge clock) begin
    if (!reset) out <= 64'd0;
    else        out <= next_pc;
  end
endmodule

module scp_imem #(
  parameter int WORDS = 256
) (
  input  logic        clock,
  input  logic        we,
  input  logic [61:0] waddr,
  input  logic [31:0] wdata,
  input  logic [61:0] word_addr,
  output logic [31:0] rdata
);
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [31:0] memory [0:WORDS-1];

  // Word write port; tied off in the core, contents normally preloaded
  always_ff @(posedge clock) begin
    if (we && (waddr < 62'(WORDS))) memory[waddr[AW-1:0]] <= wdata;
  end

  // Fetch; words past the end of the array read as zero (a NOP)
  always_comb begin
    rdata = 32'd0;
    if (word_addr < 62'(WORDS)) rdata = memory[word_addr[AW-1:0]];
  end
endmodule

module scp_dmem #(
  parameter int WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [63:0] rdata
);
  localparam int AW = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [63:0] memory [0:WORDS-1];
  logic        in_range;

  assign in_range = (addr < 64'(WORDS));

  // Doubleword store; dropped while in reset or when the address is out of range
  always_ff @(posedge clock) begin
    if (reset && we && in_range) memory[addr[AW-1:0]] <= wdata;
  end

  // Asynchronous load; out-of-range addresses return zero
  always_comb begin
    rdata = 64'd0;
    if (in_range) rdata = memory[addr[AW-1:0]];
  end
endmodule

module scp_regfile (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  Read_register_1,
  input  logic [4:0]  Read_register_2,
  input  logic [4:0]  Write_register,
  input  logic [63:0] Write_data,
  input  logic        RegWrite,
  output logic [63:0] Read_data_1,
  output logic [63:0] Read_data_2
);
  logic [63:0] regfile [0:31];

  // Single write port; X31 is the zero register so writes to it are discarded
  always_ff @(posedge clock) begin
    if (reset && RegWrite && (Write_register != 5'd31)) regfile[Write_register] <= Write_data;
  end

  // Two asynchronous read ports with X31 forced to zero
  always_comb begin
    Read_data_1 = (Read_register_1 == 5'd31) ? 64'd0 : regfile[Read_register_1];
    Read_data_2 = (Read_register_2 == 5'd31) ? 64'd0 : regfile[Read_register_2];
  end
endmodule

module single_cycle_processor #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input  logic clock,
  input  logic reset,
  output logic uitgang
);
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;

  logic [63:0] pc_out;
  logic [63:0] next_pc;
  logic [31:0] instruction;
  logic [10:0] opcode;
  logic [4:0]  rn, rm, rt;
  logic [8:0]  imm9;
  logic        is_ldur, is_stur, is_rtype, is_cbz, is_b;
  logic [4:0]  read_reg_2;
  logic [63:0] read_data_1, read_data_2;
  logic [63:0] alu_result, dmem_rdata, write_data;
  logic        reg_write;
  logic        unused_bits;

  assign opcode = instruction[31:21];
  assign rm     = instruction[20:16];
  assign imm9   = instruction[20:12];
  assign rn     = instruction[9:5];
  assign rt     = instruction[4:0];

  assign unused_bits = ^{instruction[11:10], pc_out[1:0]};

  scp_pc pc (
    .clock   (clock),
    .reset   (reset),
    .next_pc (next_pc),
    .out     (pc_out)
  );

  scp_imem #(.WORDS(IMEM_WORDS)) instruction_memory (
    .clock     (clock),
    .we        (1'b0),
    .waddr     (62'd0),
    .wdata     (32'd0),
    .word_addr (pc_out[63:2]),
    .rdata     (instruction)
  );

  // Opcode decode; anything unrecognised falls through as a NOP
  always_comb begin
    is_ldur  = (opcode == OP_LDUR);
    is_stur  = (opcode == OP_STUR);
    is_rtype = (opcode == OP_ADD) || (opcode == OP_SUB) ||
               (opcode == OP_AND) || (opcode == OP_ORR);
    is_cbz   = 1'b0;
    is_b     = 1'b0;
`ifdef SCP_BRANCH_EN
    is_cbz   = (instruction[31:24] == 8'hB4);
    is_b     = (instruction[31:26] == 6'h05);
`endif
  end

  // Second read port carries Rt for stores and CBZ, Rm otherwise
  assign read_reg_2 = (is_stur || is_cbz) ? rt : rm;
  assign reg_write  = is_ldur || is_rtype;
  assign write_data = is_ldur ? dmem_rdata : alu_result;

  scp_regfile registers (
    .clock           (clock),
    .reset           (reset),
    .Read_register_1 (rn),
    .Read_register_2 (read_reg_2),
    .Write_register  (rt),
    .Write_data      (write_data),
    .RegWrite        (reg_write),
    .Read_data_1     (read_data_1),
    .Read_data_2     (read_data_2)
  );

  // ALU: address generation for loads/stores, Rt pass-through for CBZ
  always_comb begin
    alu_result = read_data_1 + read_data_2;
    if (is_ldur || is_stur) begin
      alu_result = read_data_1 + {{55{imm9[8]}}, imm9};
    end else if (is_cbz) begin
      alu_result = read_data_2;
    end else begin
      case (opcode)
        OP_SUB:  alu_result = read_data_1 - read_data_2;
        OP_AND:  alu_result = read_data_1 & read_data_2;
        OP_ORR:  alu_result = read_data_1 | read_data_2;
        default: alu_result = read_data_1 + read_data_2;
      endcase
    end
  end

  assign uitgang = (alu_result == 64'd0);

  scp_dmem #(.WORDS(DMEM_WORDS)) data_memory (
    .clock (clock),
    .reset (reset),
    .we    (is_stur),
    .addr  (alu_result),
    .wdata (read_data_2),
    .rdata (dmem_rdata)
  );

`ifdef SCP_BRANCH_EN
  logic [18:0] imm19;
  logic [25:0] imm26;
  assign imm19 = instruction[23:5];
  assign imm26 = instruction[25:0];

  // Next PC: unconditional branch, taken CBZ, or fall-through
  always_comb begin
    next_pc = pc_out + 64'd4;
    if (is_b)                 next_pc = pc_out + {{36{imm26[25]}}, imm26, 2'b00};
    else if (is_cbz && uitgang) next_pc = pc_out + {{43{imm19[18]}}, imm19, 2'b00};
  end
`else
  // Next PC: always fall-through when branches are not built in
  always_comb begin
    next_pc = pc_out + 64'd4;
  end
`endif
endmodule

// File: tb/tb_single_cycle_processor.sv
module tb_single_cycle_processor;
  localparam int IMEM_WORDS = 256;
  localparam int DMEM_WORDS = 256;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
`ifdef SCP_BRANCH_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif

  logic clock;
  logic reset;
  logic uitgang;
  int   n_vec;
  int   n_err;

  logic [63:0] m_reg  [32];
  logic [63:0] m_dmem [DMEM_WORDS];
  logic [31:0] prog   [IMEM_WORDS];
  logic [63:0] m_pc;

  single_cycle_processor #(.IMEM_WORDS(IMEM_WORDS), .DMEM_WORDS(DMEM_WORDS)) dut (
    .clock   (clock),
    .reset   (reset),
    .uitgang (uitgang)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] rm, input logic [4:0] rn, input logic [4:0] rd);
    return {op, rm, 6'd0, rn, rd};
  endfunction

  function automatic logic [31:0] enc_d(input logic [10:0] op, input int imm, input logic [4:0] rn, input logic [4:0] rt);
    logic [8:0] i9;
    i9 = 9'(imm);
    return {op, i9, 2'b00, rn, rt};
  endfunction

  function automatic logic [31:0] enc_cbz(input int imm, input logic [4:0] rt);
    logic [18:0] i19;
    i19 = 19'(imm);
    return {8'hB4, i19, rt};
  endfunction

  function automatic logic [31:0] enc_b(input int imm);
    logic [25:0] i26;
    i26 = 26'(imm);
    return {6'h05, i26};
  endfunction

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic clear_imem();
    for (int i = 0; i < IMEM_WORDS; i++) dut.instruction_memory.memory[i] = 32'd0;
  endtask

  // Enter reset for one edge and leave it asserted so the caller can preload
  task automatic hold_reset();
    reset = 1'b0;
    tick();
    clear_imem();
  endtask

  function automatic logic [63:0] m_rd(input logic [4:0] r);
    return (r == 5'd31) ? 64'd0 : m_reg[r];
  endfunction

  // Architectural reference: one instruction applied to the model state
  task automatic model_step(output logic exp_zero, output bit zero_valid);
    logic [31:0] w;
    logic [63:0] a, b, t, res, addr;
    longint      off;
    w    = prog[int'(m_pc >> 2)];
    a    = m_rd(w[9:5]);
    b    = m_rd(w[20:16]);
    t    = m_rd(w[4:0]);
    off  = longint'($signed(w[20:12]));
    addr = a + 64'(off);
    m_pc = m_pc + 64'd4;
    zero_valid = 1'b1;
    exp_zero   = 1'b0;
    case (w[31:21])
      OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
        if (w[31:21] == OP_ADD)      res = a + b;
        else if (w[31:21] == OP_SUB) res = a - b;
        else if (w[31:21] == OP_AND) res = a & b;
        else                         res = a | b;
        exp_zero = (res == 64'd0);
        if (w[4:0] != 5'd31) m_reg[w[4:0]] = res;
      end
      OP_LDUR: begin
        exp_zero = (addr == 64'd0);
        if (w[4:0] != 5'd31) m_reg[w[4:0]] = (addr < 64'(DMEM_WORDS)) ? m_dmem[int'(addr)] : 64'd0;
      end
      OP_STUR: begin
        exp_zero = (addr == 64'd0);
        if (addr < 64'(DMEM_WORDS)) m_dmem[int'(addr)] = t;
      end
      default: zero_valid = 1'b0;
    endcase
  endtask

  task automatic test_reset();
    reset = 1'b0;
    clear_imem();
    dut.instruction_memory.memory[0] = enc_r(OP_ADD, 5'd2, 5'd1, 5'd3);
    dut.registers.regfile[1] = 64'd5;
    dut.registers.regfile[2] = 64'd3;
    dut.registers.regfile[3] = 64'hDEAD;
    tick();
    n_vec++; if (dut.pc.out !== 64'd0) begin n_err++; $display("FAIL rst_pc: got %0d expected 0", dut.pc.out); end
    n_vec++; if (dut.registers.regfile[3] !== 64'hDEAD) begin n_err++; $display("FAIL rst_nowrite: got %0h expected dead", dut.registers.regfile[3]); end
  endtask

  task automatic test_load_store();
    hold_reset();
    dut.registers.regfile[16] = 64'd20;
    dut.registers.regfile[18] = 64'd6;
    dut.registers.regfile[2]  = 64'd0;
    dut.registers.regfile[3]  = 64'd0;
    dut.data_memory.memory[20] = 64'd17;
    dut.data_memory.memory[21] = 64'd21;
    dut.data_memory.memory[22] = 64'd0;
    dut.instruction_memory.memory[0] = enc_d(OP_LDUR, 0, 5'd16, 5'd2);
    dut.instruction_memory.memory[1] = enc_d(OP_LDUR, 1, 5'd16, 5'd2);
    dut.instruction_memory.memory[2] = enc_d(OP_STUR, 0, 5'd16, 5'd18);
    dut.instruction_memory.memory[3] = enc_d(OP_STUR, 2, 5'd16, 5'd18);
    dut.instruction_memory.memory[4] = enc_d(OP_STUR, 1, 5'd16, 5'd18);
    dut.instruction_memory.memory[5] = enc_d(OP_LDUR, 1, 5'd16, 5'd3);
    reset = 1'b1;
    n_vec++; if (dut.pc.out !== 64'd0) begin n_err++; $display("FAIL ls_pc0: got %0d expected 0", dut.pc.out); end
    tick();
    n_vec++; if (dut.registers.regfile[2] !== 64'd17) begin n_err++; $display("FAIL ls_ld0: got %0d expected 17", dut.registers.regfile[2]); end
    n_vec++; if (dut.pc.out !== 64'd4) begin n_err++; $display("FAIL ls_pc4: got %0d expected 4", dut.pc.out); end
    tick();
    n_vec++; if (dut.registers.regfile[2] !== 64'd21) begin n_err++; $display("FAIL ls_ld1: got %0d expected 21", dut.registers.regfile[2]); end
    n_vec++; if (dut.pc.out !== 64'd8) begin n_err++; $display("FAIL ls_pc8: got %0d expected 8", dut.pc.out); end
    n_vec++; if (dut.registers.Read_data_2 !== 64'd6) begin n_err++; $display("FAIL ls_rd2_a: got %0d expected 6", dut.registers.Read_data_2); end
    tick();
    n_vec++; if (dut.data_memory.memory[20] !== 64'd6) begin n_err++; $display("FAIL ls_st0: got %0d expected 6", dut.data_memory.memory[20]); end
    n_vec++; if (dut.pc.out !== 64'd12) begin n_err++; $display("FAIL ls_pc12: got %0d expected 12", dut.pc.out); end
    n_vec++; if (dut.registers.Read_data_2 !== 64'd6) begin n_err++; $display("FAIL ls_rd2_b: got %0d expected 6", dut.registers.Read_data_2); end
    tick();
    n_vec++; if (dut.data_memory.memory[22] !== 64'd6) begin n_err++; $display("FAIL ls_st2: got %0d expected 6", dut.data_memory.memory[22]); end
    n_vec++; if (dut.pc.out !== 64'd16) begin n_err++; $display("FAIL ls_pc16: got %0d expected 16", dut.pc.out); end
    tick();
    n_vec++; if (dut.data_memory.memory[21] !== 64'd6) begin n_err++; $display("FAIL ls_st1: got %0d expected 6", dut.data_memory.memory[21]); end
    tick();
    n_vec++; if (dut.registers.regfile[3] !== 64'd6) begin n_err++; $display("FAIL ls_st_ld: got %0d expected 6", dut.registers.regfile[3]); end
    n_vec++; if (dut.pc.out !== 64'd24) begin n_err++; $display("FAIL ls_pc24: got %0d expected 24", dut.pc.out); end
  endtask

  task automatic test_reset_mid();
    hold_reset();
    dut.registers.regfile[1]  = 64'd5;
    dut.registers.regfile[3]  = 64'd0;
    dut.registers.regfile[16] = 64'd20;
    dut.data_memory.memory[23] = 64'd0;
    dut.instruction_memory.memory[0] = enc_r(OP_ADD, 5'd1, 5'd3, 5'd3);
    dut.instruction_memory.memory[1] = enc_d(OP_STUR, 3, 5'd16, 5'd1);
    dut.instruction_memory.memory[2] = enc_r(OP_ADD, 5'd1, 5'd3, 5'd3);
    reset = 1'b1;
    tick();
    tick();
    n_vec++; if (dut.data_memory.memory[23] !== 64'd5) begin n_err++; $display("FAIL rm_st: got %0d expected 5", dut.data_memory.memory[23]); end
    reset = 1'b0;
    tick();
    n_vec++; if (dut.pc.out !== 64'd0) begin n_err++; $display("FAIL rm_pc_a: got %0d expected 0", dut.pc.out); end
    n_vec++; if (dut.registers.regfile[3] !== 64'd5) begin n_err++; $display("FAIL rm_noreg: got %0d expected 5", dut.registers.regfile[3]); end
    reset = 1'b1;
    tick();
    n_vec++; if (dut.registers.regfile[3] !== 64'd10) begin n_err++; $display("FAIL rm_resume: got %0d expected 10", dut.registers.regfile[3]); end
    n_vec++; if (dut.pc.out !== 64'd4) begin n_err++; $display("FAIL rm_pc4: got %0d expected 4", dut.pc.out); end
    dut.data_memory.memory[23] = 64'h55;
    reset = 1'b0;
    tick();
    n_vec++; if (dut.data_memory.memory[23] !== 64'h55) begin n_err++; $display("FAIL rm_nomem: got %0h expected 55", dut.data_memory.memory[23]); end
    n_vec++; if (dut.pc.out !== 64'd0) begin n_err++; $display("FAIL rm_pc_b: got %0d expected 0", dut.pc.out); end
    reset = 1'b1;
  endtask

  task automatic test_alu();
    hold_reset();
    dut.registers.regfile[1] = 64'd5;
    dut.registers.regfile[2] = 64'd3;
    for (int i = 3; i < 8; i++) dut.registers.regfile[i] = 64'hFF;
    dut.instruction_memory.memory[0] = enc_r(OP_ADD, 5'd2, 5'd1, 5'd3);
    dut.instruction_memory.memory[1] = enc_r(OP_SUB, 5'd1, 5'd1, 5'd4);
    dut.instruction_memory.memory[2] = enc_r(OP_AND, 5'd2, 5'd1, 5'd6);
    dut.instruction_memory.memory[3] = enc_r(OP_ORR, 5'd2, 5'd1, 5'd7);
    reset = 1'b1;
    n_vec++; if (uitgang !== 1'b0) begin n_err++; $display("FAIL alu_z_add: got %0b expected 0", uitgang); end
    tick();
    n_vec++; if (dut.registers.regfile[3] !== 64'd8) begin n_err++; $display("FAIL alu_add: got %0d expected 8", dut.registers.regfile[3]); end
    n_vec++; if (uitgang !== 1'b1) begin n_err++; $display("FAIL alu_z_sub: got %0b expected 1", uitgang); end
    tick();
    n_vec++; if (dut.registers.regfile[4] !== 64'd0) begin n_err++; $display("FAIL alu_sub: got %0d expected 0", dut.registers.regfile[4]); end
    tick();
    n_vec++; if (dut.registers.regfile[6] !== 64'd1) begin n_err++; $display("FAIL alu_and: got %0d expected 1", dut.registers.regfile[6]); end
    tick();
    n_vec++; if (dut.registers.regfile[7] !== 64'd7) begin n_err++; $display("FAIL alu_orr: got %0d expected 7", dut.registers.regfile[7]); end
  endtask

  task automatic test_x31();
    hold_reset();
    dut.registers.regfile[1]  = 64'd5;
    dut.registers.regfile[2]  = 64'd3;
    dut.registers.regfile[5]  = 64'd0;
    dut.registers.regfile[31] = 64'd99;
    dut.instruction_memory.memory[0] = enc_r(OP_ADD, 5'd2, 5'd1, 5'd31);
    dut.instruction_memory.memory[1] = enc_r(OP_ADD, 5'd1, 5'd31, 5'd5);
    reset = 1'b1;
    tick();
    n_vec++; if (dut.registers.regfile[31] !== 64'd99) begin n_err++; $display("FAIL x31_nowrite: got %0d expected 99", dut.registers.regfile[31]); end
    tick();
    n_vec++; if (dut.registers.regfile[5] !== 64'd5) begin n_err++; $display("FAIL x31_readzero: got %0d expected 5", dut.registers.regfile[5]); end
  endtask

  task automatic test_branch();
    hold_reset();
    dut.registers.regfile[9] = 64'd0;
    dut.instruction_memory.memory[2] = enc_cbz(3, 5'd9);
    dut.instruction_memory.memory[5] = enc_b(-2);
    reset = 1'b1;
    tick(); tick(); tick();
    n_vec++; if (dut.pc.out !== (BR ? 64'd20 : 64'd12)) begin n_err++; $display("FAIL br_cbz_taken: got %0d expected %0d", dut.pc.out, BR ? 20 : 12); end
    hold_reset();
    dut.registers.regfile[9] = 64'd1;
    dut.instruction_memory.memory[2] = enc_cbz(3, 5'd9);
    dut.instruction_memory.memory[5] = enc_b(-2);
    reset = 1'b1;
    tick(); tick(); tick();
    n_vec++; if (dut.pc.out !== 64'd12) begin n_err++; $display("FAIL br_cbz_not: got %0d expected 12", dut.pc.out); end
    tick(); tick();
    n_vec++; if (dut.pc.out !== 64'd20) begin n_err++; $display("FAIL br_pc20: got %0d expected 20", dut.pc.out); end
    tick();
    n_vec++; if (dut.pc.out !== (BR ? 64'd12 : 64'd24)) begin n_err++; $display("FAIL br_b: got %0d expected %0d", dut.pc.out, BR ? 12 : 24); end
  endtask

  task automatic test_nop_oob();
    logic [63:0] snap [32];
    hold_reset();
    for (int i = 0; i < 31; i++) dut.registers.regfile[i] = {$urandom, $urandom};
    dut.registers.regfile[17] = 64'(DMEM_WORDS);
    dut.registers.regfile[2]  = 64'd77;
    dut.data_memory.memory[20] = 64'h1234;
    for (int i = 0; i < 31; i++) snap[i] = dut.registers.regfile[i];
    dut.instruction_memory.memory[1] = enc_d(OP_LDUR, 0, 5'd17, 5'd2);
    dut.instruction_memory.memory[2] = enc_d(OP_STUR, 20, 5'd17, 5'd1);
    reset = 1'b1;
    tick();
    n_vec++; if (dut.pc.out !== 64'd4) begin n_err++; $display("FAIL nop_pc: got %0d expected 4", dut.pc.out); end
    for (int i = 0; i < 31; i++) begin
      n_vec++; if (dut.registers.regfile[i] !== snap[i]) begin n_err++; $display("FAIL nop_x%0d: got %0h expected %0h", i, dut.registers.regfile[i], snap[i]); end
    end
    tick();
    n_vec++; if (dut.registers.regfile[2] !== 64'd0) begin n_err++; $display("FAIL oob_ld: got %0d expected 0", dut.registers.regfile[2]); end
    tick();
    n_vec++; if (dut.data_memory.memory[20] !== 64'h1234) begin n_err++; $display("FAIL oob_st: got %0h expected 1234", dut.data_memory.memory[20]); end
    n_vec++; if (dut.pc.out !== 64'd12) begin n_err++; $display("FAIL oob_pc: got %0d expected 12", dut.pc.out); end
  endtask

  task automatic test_random();
    localparam int N = 40;
    for (int i = 0; i < IMEM_WORDS; i++) prog[i] = 32'd0;
    for (int i = 0; i < N; i++) begin
      int          k;
      logic [4:0]  dst, base;
      k    = int'($urandom_range(0, 6));
      dst  = 5'($urandom_range(0, 16));
      if (dst == 5'd16) dst = 5'd31;
      base = ($urandom_range(0, 3) == 0) ? 5'd21 : 5'd20;
      case (k)
        0: prog[i] = enc_r(OP_ADD, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), dst);
        1: prog[i] = enc_r(OP_SUB, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), dst);
        2: prog[i] = enc_r(OP_AND, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), dst);
        3: prog[i] = enc_r(OP_ORR, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), dst);
        4: prog[i] = enc_d(OP_LDUR, int'($urandom_range(0, 16)) - 8, base, dst);
        5: prog[i] = enc_d(OP_STUR, int'($urandom_range(0, 16)) - 8, base, 5'($urandom_range(0, 31)));
        default: prog[i] = 32'd0;
      endcase
    end
    for (int i = 0; i < 32; i++) m_reg[i] = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 7)) : {$urandom, $urandom};
    m_reg[20] = 64'($urandom_range(10, 200));
    m_reg[21] = 64'hFFFF_FFFF_FFFF_FFF0;
    for (int i = 0; i < DMEM_WORDS; i++) m_dmem[i] = {$urandom, $urandom};
    hold_reset();
    for (int i = 0; i < 32; i++) dut.registers.regfile[i] = m_reg[i];
    for (int i = 0; i < DMEM_WORDS; i++) dut.data_memory.memory[i] = m_dmem[i];
    for (int i = 0; i < IMEM_WORDS; i++) dut.instruction_memory.memory[i] = prog[i];
    m_pc  = 64'd0;
    reset = 1'b1;
    for (int s = 0; s < N; s++) begin
      logic ez;
      bit   zv;
      model_step(ez, zv);
      if (zv) begin
        n_vec++; if (uitgang !== ez) begin n_err++; $display("FAIL rnd_zero s%0d: got %0b expected %0b", s, uitgang, ez); end
      end
      tick();
      n_vec++; if (dut.pc.out !== m_pc) begin n_err++; $display("FAIL rnd_pc s%0d: got %0d expected %0d", s, dut.pc.out, m_pc); end
      for (int r = 0; r < 31; r++) begin
        n_vec++; if (dut.registers.regfile[r] !== m_reg[r]) begin n_err++; $display("FAIL rnd_x%0d s%0d: got %0h expected %0h", r, s, dut.registers.regfile[r], m_reg[r]); end
      end
    end
    for (int i = 0; i < DMEM_WORDS; i++) begin
      n_vec++; if (dut.data_memory.memory[i] !== m_dmem[i]) begin n_err++; $display("FAIL rnd_dmem%0d: got %0h expected %0h", i, dut.data_memory.memory[i], m_dmem[i]); end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    test_reset();
    test_load_store();
    test_reset_mid();
    test_alu();
    test_x31();
    test_branch();
    test_nop_oob();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/single_cycle_processor.md
# single_cycle_processor

Single-cycle LEGv8/ARMv8-subset CPU core: fetch, decode, register read, ALU, data-memory access and write-back complete in one clock period. It is the top-level datapath of the processor project; the pipelined version is derived from it. Memories and register file are internal arrays that benches preload by hierarchical reference.

## Interface
Parameters:
- IMEM_WORDS, 256: instruction memory depth in 32-bit words.
- DMEM_WORDS, 256: data memory depth in 64-bit doublewords.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  one clock; reset is synchronous and active-low.
- uitgang  output  1  ALU zero flag of the current instruction (1 when ALU result == 0).

Required internal hierarchy, which benches access directly:
- registers.regfile[0:31] (64-bit)
- registers.Read_data_2
- pc.out (64-bit PC)
- instruction_memory.memory[0:IMEM_WORDS-1] (32-bit)
- data_memory.memory[0:DMEM_WORDS-1] (64-bit)
- instruction (32-bit fetched word)

## Operation
- Fetch: instruction = instruction_memory.memory[pc.out[63:2]]. An index beyond the memory depth reads 0.
- Decode on opcode fields; all other encodings are NOP (no writes, PC+4):
  - LDUR 11'h7C2: Rt ← dmem[Rn + sext(imm9[20:12])].
  - STUR 11'h7C0: dmem[Rn + sext(imm9)] ← Rt.
  - ADD 11'h458, SUB 11'h658, AND 11'h450, ORR 11'h550: Rd ← Rn op Rm.
  - CBZ 8'hB4: if Rt == 0, PC ← PC + (sext(imm19) << 2).
  - B 6'h05: PC ← PC + (sext(imm26) << 2).
- Data memory is doubleword-indexed: address = Rn + sext(imm9), unscaled, and the low bits of that sum select the entry directly. Out-of-range loads return 0; out-of-range stores are dropped.
- Register file:
  - Two asynchronous read ports: Read_data_1 = Rn. Read_data_2 = Rm for R-type and Rt for STUR/CBZ.
  - One synchronous write port.
  - X31 reads as 0, and writes to X31 are discarded.
- ALU is 64-bit, modulo 2^64, with no flags except zero. uitgang reflects it combinationally.
- Register file and memories are not cleared by reset; contents come from preload or prior writes.

## Timing
- One instruction per clock. Reads are combinational within the cycle. Register write, memory write and PC update occur together at the rising edge.
- Reset (reset == 0 at a rising edge): PC ← 0, and all register and memory writes are suppressed that cycle.
- First instruction (address 0) executes on the first rising edge with reset == 1.
- Reset asserted mid-program: the in-flight instruction does not commit and PC returns to 0.
- LDUR followed by an instruction reading Rt sees the loaded value, because the write completes at the edge.
- Store and load to the same address in consecutive cycles: the load returns the new data.
- PC wraps modulo 2^64. A branch to the current PC (offset 0) loops indefinitely.
- uitgang has no reset value of its own; it follows the combinational ALU result (0 while the ALU result is nonzero).

## Configuration
- SCP_BRANCH_EN defined: CBZ and B are implemented as above.
- SCP_BRANCH_EN undefined: CBZ and B decode as NOP and PC always advances by 4; the branch adder and mux are omitted.

## Test plan
- Preload X16=20, X18=6, dmem[20]=17, dmem[21]=21. Run LDUR X2,[X16,#0]; LDUR X2,[X16,#1]; STUR X18,[X16,#0]; STUR X18,[X16,#2] -> X2=17 after edge 1 and 21 after edge 2; dmem[20]=6 after edge 3; dmem[22]=6 after edge 4. pc.out steps 0,4,8,12,16; Read_data_2=6 during both STURs.
- Hold reset low for one edge mid-run -> pc.out=0 and no register or memory change on that edge; execution then resumes from address 0.
- X1=5, X2=3: ADD X3,X1,X2 -> 8. SUB X4,X1,X1 -> 0 with uitgang=1. AND -> 1. ORR -> 7.
- ADD X31,X1,X2, then ADD X5,X31,X1 -> X31 still reads 0 and X5=5.
- With SCP_BRANCH_EN: X9=0, CBZ X9,#3 at PC 8 -> PC 20. X9=1 -> PC 12. B #-2 at PC 20 -> PC 12. Without the macro, all three -> PC+4.
- Undefined word 32'h00000000 -> no state change and PC+4. LDUR with address ≥ DMEM_WORDS -> Rt=0.
